vga_frame_sync_sched: RTL and testbench

- Write scheduler between the HPS lightweight bus and the sprite/score display register file of the VGA sprite renderer.
- Software writes (sprite x/y, score, score position) are queued in a FIFO and committed to the display registers only during vertical blanking, so a frame never shows a half-updated scene.
- Also provides a per-frame tick, status readback, and an immediate (bypass) mode for bring-up.

---
 rtl/vga_sched_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/vga_frame_sync_sched.sv | 187 ++++++++++++++++++
 tb/tb_vga_frame_sync_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sched_pkg.sv
// Shared types and constants for the VGA frame-synchronous write scheduler.
//   - sched_state_t : scheduler FSM states
//   - entry_t       : one queued display-register write {addr, data}
//   - control register bit indices and status field offsets
package vga_sched_pkg;

   localparam int SCHED_ADDR_W = 9;
   localparam int SCHED_DATA_W = 32;

   localparam logic [SCHED_ADDR_W-1:0] CTRL_ADDR_DEFAULT = 9'h1FF;

   // control register write bits
   localparam int CLR_OVF = 0;
   localparam int IMM     = 1;

   // status readback layout
   localparam int STAT_VBLANK  = 0;
   localparam int STAT_IMM     = 1;
   localparam int STAT_OVF     = 2;
   localparam int STAT_LEVEL   = 3;
   localparam int STAT_LEVEL_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } sched_state_t;

   typedef struct packed {
      logic [SCHED_ADDR_W-1:0] addr;
      logic [SCHED_DATA_W-1:0] data;
   } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and a combinational head.
// Ports:
//   clk, reset_n : clock, async active-low reset (discards contents)
//   push, wdata  : write request and data; accepted when not full, or when
//                  full with a simultaneous pop
//   pop, rdata   : read request; rdata shows the current head entry
//   full, empty  : occupancy flags
//   level        : occupancy, 0..DEPTH
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == LVL_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // a pop in the same cycle frees the slot the push writes into
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];
   assign level   = count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + LVL_W'(1);
            2'b01:   count <= count - LVL_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/vga_frame_sync_sched.sv
// Frame-synchronous write scheduler between the HPS lightweight bus and the
// sprite/score display registers. Writes are queued and committed only during
// vertical blanking; an immediate mode forwards writes straight through.
// Ports:
//   clk, reset_n           : clock, async active-low reset
//   chipselect/write/read  : bus strobes
//   address, writedata     : bus word address and write data
//   readdata               : status, valid the cycle after a read strobe
//   vcount                 : current VGA line
//   reg_we/addr/wdata      : one-cycle display-register write
//   frame_tick             : pulse one cycle after blanking starts
//   overflow               : sticky, a queued write was dropped (FIFO full)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for the start of vertical blanking
// DRAIN | committing the batch captured at blanking start, one per cycle
// DONE  | batch committed, waiting for blanking to end
module vga_frame_sync_sched
   import vga_sched_pkg::*;
#(
   parameter int                ADDR_W    = SCHED_ADDR_W,
   parameter int                DATA_W    = SCHED_DATA_W,
   parameter int                DEPTH     = 16,
   parameter int                VACTIVE   = 480,
   parameter logic [ADDR_W-1:0] CTRL_ADDR = CTRL_ADDR_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              chipselect,
   input  logic              write,
   input  logic              read,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   input  logic [9:0]        vcount,
   output logic              reg_we,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              frame_tick,
   output logic              overflow
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   sched_state_t      state_q;
   sched_state_t      state_d;
   logic [LVL_W-1:0]  batch_q;
   logic              batch_load;
   logic              batch_dec;

   logic              in_vblank;
   logic              vb_q;
   logic              vblank_rise;
   logic              imm_mode;

   logic              ctrl_hit;
   logic              bus_wr;
   logic              ctrl_wr;
   logic              bypass_wr;
   logic              q_wr;
   logic              drop;

   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [LVL_W-1:0]  level;
   entry_t            wr_entry;
   entry_t            rd_entry;
   logic [DATA_W-1:0] status;

   assign in_vblank   = (vcount >= 10'(VACTIVE));
   assign vblank_rise = in_vblank & ~vb_q;

   assign ctrl_hit  = (address == CTRL_ADDR);
   assign bus_wr    = chipselect & write;
   assign ctrl_wr   = bus_wr & ctrl_hit;
   assign bypass_wr = bus_wr & ~ctrl_hit & imm_mode;
   assign q_wr      = bus_wr & ~ctrl_hit & ~imm_mode;
   assign drop      = q_wr & fifo_full & ~pop;

   assign wr_entry.addr = address;
   assign wr_entry.data = writedata;

   sync_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (q_wr),
      .wdata   (wr_entry),
      .pop     (pop),
      .rdata   (rd_entry),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // a bypass write owns the output register, so the drain pop waits a cycle
   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      batch_load = 1'b0;
      batch_dec  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (vblank_rise) begin
               batch_load = 1'b1;
               state_d    = (level != '0) ? DRAIN : DONE;
            end
         end
         DRAIN: begin
            if (!in_vblank) begin
               state_d = IDLE;
            end else if (!bypass_wr && !fifo_empty) begin
               pop       = 1'b1;
               batch_dec = 1'b1;
               if (batch_q == LVL_W'(1)) state_d = DONE;
            end
         end
         DONE: begin
            if (!in_vblank) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // batch is a down-counter: only entries present at blanking start commit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        batch_q <= '0;
      else if (batch_load) batch_q <= level;
      else if (batch_dec)  batch_q <= batch_q - LVL_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vb_q       <= 1'b0;
         frame_tick <= 1'b0;
         imm_mode   <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         vb_q       <= in_vblank;
         frame_tick <= vblank_rise;
         if (ctrl_wr) imm_mode <= writedata[IMM];
         if (ctrl_wr && writedata[CLR_OVF]) overflow <= 1'b0;
         else if (drop)                     overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reg_we    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
      end else begin
         reg_we <= bypass_wr | pop;
         if (bypass_wr) begin
            reg_addr  <= address;
            reg_wdata <= writedata;
         end else if (pop) begin
            reg_addr  <= rd_entry.addr;
            reg_wdata <= rd_entry.data;
         end
      end
   end

   always_comb begin
      status                                    = '0;
      status[STAT_VBLANK]                       = in_vblank;
      status[STAT_IMM]                          = imm_mode;
      status[STAT_OVF]                          = overflow;
      status[STAT_LEVEL +: STAT_LEVEL_W]        = STAT_LEVEL_W'(level);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                           readdata <= '0;
      else if (chipselect && read && ctrl_hit) readdata <= status;
      else                                     readdata <= '0;
   end

endmodule

// File: tb/tb_vga_frame_sync_sched.sv
// Self-checking bench for vga_frame_sync_sched: expected commits are queued
// when writes are issued and compared as reg_we pulses appear.
module tb_vga_frame_sync_sched;

   localparam logic [8:0] CTRL = 9'h1FF;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        chipselect = 1'b0;
   logic        write = 1'b0;
   logic        read = 1'b0;
   logic [8:0]  address = '0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [9:0]  vcount = '0;
   logic        reg_we;
   logic [8:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic        frame_tick;
   logic        overflow;

   always #10 clk = ~clk;

   vga_frame_sync_sched dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .chipselect (chipselect),
      .write      (write),
      .read       (read),
      .address    (address),
      .writedata  (writedata),
      .readdata   (readdata),
      .vcount     (vcount),
      .reg_we     (reg_we),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .frame_tick (frame_tick),
      .overflow   (overflow)
   );

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic [8:0]  a;
      logic [31:0] d;
   } exp_t;

   exp_t sb[$];
   int   commit_cnt = 0;
   int   tick_cnt = 0;
   int   cyc = 0;
   int   first_commit_cyc = 0;
   int   last_commit_cyc = 0;
   bit   imm_exp = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset_n) begin
         if (frame_tick) tick_cnt++;
         if (reg_we) begin
            if (!imm_exp) chk("commit_in_vblank", 64'(vcount >= 10'd480), 64'd1);
            if (sb.size() == 0) begin
               chk("unexpected_commit", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("commit_addr", 64'(reg_addr), 64'(e.a));
               chk("commit_data", 64'(reg_wdata), 64'(e.d));
            end
            if (commit_cnt == 0) first_commit_cyc = cyc;
            last_commit_cyc = cyc;
            commit_cnt++;
         end
      end
   end

   function automatic logic [31:0] stat(input int lvl, input bit ovf, input bit imm, input bit vb);
      logic [4:0] l5;
      l5 = lvl[4:0];
      return {24'b0, l5, ovf, imm, vb};
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_vcount(input logic [9:0] v);
      @(posedge clk);
      #1 vcount = v;
   endtask

   task automatic bus_wr(input logic [8:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(posedge clk);
      #1;
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic q_write(input logic [8:0] a, input logic [31:0] d);
      bus_wr(a, d);
      sb.push_back('{a: a, d: d});
   endtask

   task automatic bus_rd(input logic [8:0] a, output logic [31:0] d);
      @(posedge clk);
      #1;
      chipselect = 1'b1; read = 1'b1; address = a;
      @(posedge clk);
      #1;
      chipselect = 1'b0; read = 1'b0;
      d = readdata;
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_reg_we"},     64'(reg_we),     64'd0);
      chk({pfx, "_reg_addr"},   64'(reg_addr),   64'd0);
      chk({pfx, "_reg_wdata"},  64'(reg_wdata),  64'd0);
      chk({pfx, "_frame_tick"}, 64'(frame_tick), 64'd0);
      chk({pfx, "_overflow"},   64'(overflow),   64'd0);
      chk({pfx, "_readdata"},   64'(readdata),   64'd0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] rd;
      int guard;

      // reset state
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      reset_n = 1'b1;

      // queue three writes, commit at blanking
      set_vcount(10'd100);
      q_write(9'd0, 32'd50);
      q_write(9'd1, 32'd80);
      q_write(9'd10, 32'd7);
      set_vcount(10'd479);
      wait_cycles(5);
      chk("t1_no_early_commit", 64'(commit_cnt), 64'd0);
      tick_cnt = 0;
      set_vcount(10'd480);
      wait_cycles(12);
      chk("t1_commits", 64'(commit_cnt), 64'd3);
      chk("t1_consecutive", 64'(last_commit_cyc - first_commit_cyc), 64'd2);
      chk("t1_ticks", 64'(tick_cnt), 64'd1);
      set_vcount(10'd0);
      wait_cycles(3);
      chk("t1_sb_empty", 64'(sb.size()), 64'd0);

      // overflow and clear
      set_vcount(10'd100);
      for (int i = 0; i < 17; i++) begin
         if (i < 16) q_write(9'(i), 32'(1000 + i));
         else        bus_wr(9'd16, 32'd9999);
      end
      chk("t2_overflow_set", 64'(overflow), 64'd1);
      bus_rd(CTRL, rd);
      chk("t2_status_full", 64'(rd), 64'(stat(16, 1'b1, 1'b0, 1'b0)));
      commit_cnt = 0;
      set_vcount(10'd480);
      wait_cycles(30);
      chk("t2_commits", 64'(commit_cnt), 64'd16);
      set_vcount(10'd0);
      wait_cycles(2);
      chk("t2_overflow_sticky", 64'(overflow), 64'd1);
      bus_wr(CTRL, 32'h1);
      chk("t2_overflow_clr", 64'(overflow), 64'd0);

      // batch cut-off: a write during DRAIN waits for the next frame
      set_vcount(10'd100);
      q_write(9'd20, 32'd1);
      q_write(9'd21, 32'd2);
      commit_cnt = 0;
      set_vcount(10'd480);
      q_write(9'd22, 32'd3);
      wait_cycles(10);
      chk("t3_commits_first", 64'(commit_cnt), 64'd2);
      bus_rd(CTRL, rd);
      chk("t3_status_vb", 64'(rd), 64'(stat(1, 1'b0, 1'b0, 1'b1)));
      set_vcount(10'd0);
      wait_cycles(2);
      bus_rd(CTRL, rd);
      chk("t3_status_active", 64'(rd), 64'(stat(1, 1'b0, 1'b0, 1'b0)));
      commit_cnt = 0;
      set_vcount(10'd480);
      wait_cycles(10);
      chk("t3_commits_second", 64'(commit_cnt), 64'd1);
      set_vcount(10'd0);
      wait_cycles(2);

      // immediate mode
      bus_wr(CTRL, 32'h2);
      imm_exp = 1'b1;
      set_vcount(10'd100);
      bus_wr(9'd4, 32'd300);
      sb.push_back('{a: 9'd4, d: 32'd300});
      chk("t4_imm_we", 64'(reg_we), 64'd1);
      chk("t4_imm_addr", 64'(reg_addr), 64'd4);
      chk("t4_imm_data", 64'(reg_wdata), 64'd300);
      wait_cycles(1);
      chk("t4_imm_we_drop", 64'(reg_we), 64'd0);
      bus_rd(CTRL, rd);
      chk("t4_status", 64'(rd), 64'(stat(0, 1'b0, 1'b1, 1'b0)));
      set_vcount(10'd600);
      wait_cycles(3);
      commit_cnt = 0;
      bus_wr(9'd5, 32'd9);
      sb.push_back('{a: 9'd5, d: 32'd9});
      wait_cycles(2);
      chk("t4_imm_vb_commit", 64'(commit_cnt), 64'd1);
      set_vcount(10'd0);
      wait_cycles(2);

      // queued entries drain in immediate mode; a bypass write wins a collision
      bus_wr(CTRL, 32'h0);
      imm_exp = 1'b0;
      q_write(9'd30, 32'd11);
      q_write(9'd31, 32'd12);
      bus_wr(CTRL, 32'h2);
      imm_exp = 1'b1;
      commit_cnt = 0;
      set_vcount(10'd480);
      bus_wr(9'd6, 32'd77);
      sb.push_front('{a: 9'd6, d: 32'd77});
      wait_cycles(10);
      chk("t5_commits", 64'(commit_cnt), 64'd3);
      chk("t5_sb_empty", 64'(sb.size()), 64'd0);
      set_vcount(10'd0);
      bus_wr(CTRL, 32'h0);
      imm_exp = 1'b0;
      wait_cycles(2);

      // reset during drain
      set_vcount(10'd100);
      for (int i = 0; i < 8; i++) q_write(9'(40 + i), 32'(500 + i));
      commit_cnt = 0;
      set_vcount(10'd480);
      guard = 0;
      while (commit_cnt < 3 && guard < 50) begin
         @(negedge clk);
         #1;
         guard++;
      end
      chk("t6_third_commit_seen", 64'(commit_cnt), 64'd3);
      reset_n = 1'b0;
      #1;
      chk_all_zero("t6_reset");
      sb.delete();
      wait_cycles(2);
      reset_n = 1'b1;
      commit_cnt = 0;
      wait_cycles(20);
      set_vcount(10'd0);
      wait_cycles(3);
      set_vcount(10'd480);
      wait_cycles(10);
      chk("t6_no_commit_after", 64'(commit_cnt), 64'd0);
      bus_rd(CTRL, rd);
      chk("t6_status", 64'(rd), 64'(stat(0, 1'b0, 1'b0, 1'b1)));

      // status read in blanking with five queued
      for (int i = 0; i < 5; i++) q_write(9'(50 + i), 32'(i));
      bus_rd(CTRL, rd);
      chk("t7_status", 64'(rd), 64'(stat(5, 1'b0, 1'b0, 1'b1)));
      set_vcount(10'd0);
      wait_cycles(2);
      commit_cnt = 0;
      set_vcount(10'd480);
      wait_cycles(12);
      chk("t7_commits", 64'(commit_cnt), 64'd5);
      chk("t7_sb_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
